// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo_gen2 family.
package sync_fifo_pkg;

  // Read-mode selectors for the SHOWAHEAD parameter.
  localparam int FIFO_NORMAL    = 0;
  localparam int FIFO_SHOWAHEAD = 1;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: indexes 0..depth-1 and wraps naturally for power-of-two depths.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers and counter define validity.
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The head word is always visible so show-ahead mode can present it directly.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO: pointers, occupancy counter, status flags, error pulses
// and the normal/show-ahead output selection around a 2-port register array.
module sync_fifo_gen2
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int SHOWAHEAD  = 0,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   usedw,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LVL);

  // Parameter sanity checks, evaluated at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_gen2: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_gen2: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("sync_fifo_gen2: AFULL_LVL must be in 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_gen2: AEMPTY_LVL must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_usedw;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_rdata;
  logic [CW-1:0]    w_usedw_next;

  // Flags come straight from the counter register, so they never glitch.
  assign w_full   = (r_usedw == FULL_CNT);
  assign w_empty  = (r_usedw == '0);

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // clear wins over any concurrent write, so the array is not touched then.
  assign w_mem_we = w_wr_acc && !clear;

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Occupancy moves only when exactly one side of the FIFO is accepted.
  always_comb begin
    w_usedw_next = r_usedw;
    if (w_wr_acc && !w_rd_acc) begin
      w_usedw_next = r_usedw + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_usedw_next = r_usedw - CW'(1);
    end
  end

  // Pointer, counter, registered read data and error-pulse state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_usedw     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_usedw     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= w_rdata;
      end
      r_usedw     <= w_usedw_next;
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
    end
  end

  // Show-ahead exposes the head word directly; normal mode presents the popped word.
  assign data_out     = (SHOWAHEAD == FIFO_SHOWAHEAD) ? w_rdata : r_dout;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_usedw >= AFULL_CNT);
  assign almost_empty = (r_usedw <= AEMPTY_CNT);
  assign usedw        = r_usedw;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
